// File: rtl/lfsr_seed_packer_pkg.sv
// Shared constants and types for the LFSR seed packer and its neighbours
// (LFSR source and board loader).
package lfsr_seed_packer_pkg;

    localparam int WORD_W    = 8;
    localparam int NUM_WORDS = 8;
    localparam int SEED_W    = WORD_W * NUM_WORDS;
    localparam int WCNT_W    = $clog2(NUM_WORDS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } pack_state_t;

    typedef logic [SEED_W-1:0] seed_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/lfsr_seed_packer_if.sv
// Seed delivery bus: packed seed with a valid/ready handshake toward the board loader.
interface lfsr_seed_packer_if;
    import lfsr_seed_packer_pkg::*;

    seed_t seed_out;
    logic  seed_valid;
    logic  seed_ready;

    modport master (
        output seed_out,
        output seed_valid,
        input  seed_ready
    );

    modport slave (
        input  seed_out,
        input  seed_valid,
        output seed_ready
    );

endinterface

// File: rtl/lfsr_seed_packer_stride_timer.sv
// Modulo-STRIDE counter; cap is high for one cycle on the last count while enabled.
module lfsr_seed_packer_stride_timer #(
    parameter int STRIDE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic cap
);

    localparam int CNT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STRIDE - 1);

    logic [CNT_W-1:0] stride_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stride_cnt <= '0;
        end else if (clr) begin
            stride_cnt <= '0;
        end else if (en) begin
            stride_cnt <= (stride_cnt == LAST) ? '0 : stride_cnt + 1'b1;
        end
    end

    assign cap = en && (stride_cnt == LAST);

endmodule

// File: rtl/lfsr_seed_packer.sv
// Samples the free-running LFSR word every STRIDE clocks, packs NUM_WORDS samples
// into one seed and hands it downstream over valid/ready.
module lfsr_seed_packer
    import lfsr_seed_packer_pkg::*;
#(
    parameter int STRIDE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  word_t                 rnd_word,
    lfsr_seed_packer_if.master    seed_bus,
    output logic                  busy
);

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

    pack_state_t       state;
    logic [WCNT_W-1:0] word_cnt;
    seed_t             shreg;
    seed_t             packed_p0;
    seed_t             seed_q;
    logic              seed_valid_q;
    logic              filling;
    logic              cap;

    // An all-zero seed would load an empty board, so it is replaced by 1.
    function automatic seed_t zero_guard(input seed_t value);
        return (value == '0) ? SEED_W'(1) : value;
    endfunction

    assign filling   = (state == FILL);
    assign packed_p0 = {shreg[SEED_W-WORD_W-1:0], rnd_word};

    // Counter sits at zero outside FILL, so every fill starts a fresh stride.
    lfsr_seed_packer_stride_timer #(
        .STRIDE (STRIDE)
    ) u_stride_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (!filling),
        .en    (filling),
        .cap   (cap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            shreg        <= '0;
            seed_q       <= '0;
            seed_valid_q <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        word_cnt <= '0;
                        shreg    <= '0;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (cap) begin
                        shreg    <= packed_p0;
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            seed_q       <= zero_guard(packed_p0);
                            seed_valid_q <= 1'b1;
                            state        <= HOLD;
                            busy         <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (seed_bus.seed_ready) begin
                        seed_valid_q <= 1'b0;
                        if (start) begin
                            state    <= FILL;
                            word_cnt <= '0;
                            shreg    <= '0;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign seed_bus.seed_out   = seed_q;
    assign seed_bus.seed_valid = seed_valid_q;

endmodule

// File: tb/tb_lfsr_seed_packer.sv
// Scoreboard bench for lfsr_seed_packer: default STRIDE instance plus a STRIDE=1 instance.
module tb_lfsr_seed_packer;
    import lfsr_seed_packer_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  start;
    logic  start2;
    word_t rnd_word;
    logic  ready;
    logic  ready2;
    logic  busy;
    logic  busy2;

    lfsr_seed_packer_if bus ();
    lfsr_seed_packer_if bus2 ();

    assign bus.seed_ready  = ready;
    assign bus2.seed_ready = ready2;

    lfsr_seed_packer #(.STRIDE(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rnd_word (rnd_word),
        .seed_bus (bus),
        .busy     (busy)
    );

    lfsr_seed_packer #(.STRIDE(1)) dut_s1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .rnd_word (rnd_word),
        .seed_bus (bus2),
        .busy     (busy2)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    seed_t exp_q[$];
    bit    cnt_mode;
    int    n;

    localparam seed_t SEED_COUNT = 64'h0810_1820_2830_3840;
    localparam seed_t SEED_A5    = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam seed_t SEED_S1    = 64'h0102_0304_0506_0708;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; in counting mode rnd_word = n at edge E0+n.
    task automatic tick();
        @(negedge clk);
        if (cnt_mode) begin
            n++;
            rnd_word = 8'(n);
        end
    endtask

    task automatic launch(input bit counting, input word_t val, input seed_t exp);
        cnt_mode = counting;
        n        = 0;
        rnd_word = counting ? 8'h00 : val;
        start    = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic check_seed(input string tag, input seed_t obs);
        seed_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic wait_seed(input string tag, input bit noise);
        int t;
        tick();
        t     = 1;
        start = 1'b0;
        ready = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_vld_low"}, 64'(bus.seed_valid), 64'd0);
        while (!bus.seed_valid && t < 300) begin
            if (noise) begin
                start = (t == 10);
                ready = (t < 60) ? t[0] : 1'b0;
            end
            tick();
            t++;
        end
        start = 1'b0;
        ready = 1'b0;
        chk({tag, "_lat"}, 64'(t), 64'd65);
        chk({tag, "_busy_hold"}, 64'(busy), 64'd0);
        check_seed(tag, bus.seed_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stable;
        int t;
        reset    = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        ready    = 1'b0;
        ready2   = 1'b0;
        rnd_word = '0;
        cnt_mode = 1'b0;
        n        = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.seed_valid), 64'd0);
        chk("rst_seed", bus.seed_out, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        tick();

        launch(1'b1, 8'h00, SEED_COUNT);
        wait_seed("count", 1'b0);
        cnt_mode = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("hs_drop", 64'(bus.seed_valid), 64'd0);
        chk("hs_keep", bus.seed_out, SEED_COUNT);

        // seed_ready in IDLE must not start anything
        repeat (3) begin
            ready = ~ready;
            tick();
        end
        ready = 1'b0;
        chk("idle_vld", 64'(bus.seed_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        launch(1'b0, 8'hA5, SEED_A5);
        wait_seed("a5", 1'b0);
        rnd_word = 8'h00;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!bus.seed_valid || bus.seed_out !== SEED_A5) stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'd1);

        // handshake with start high restarts immediately
        ready = 1'b1;
        launch(1'b1, 8'h00, SEED_COUNT);
        wait_seed("b2b", 1'b0);

        ready = 1'b1;
        launch(1'b0, 8'h00, 64'h1);
        wait_seed("zero", 1'b0);

        ready = 1'b1;
        tick();
        ready = 1'b0;
        launch(1'b1, 8'h00, SEED_COUNT);
        tick();
        start = 1'b0;
        repeat (29) tick();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(bus.seed_valid), 64'd0);
        chk("mid_rst_seed", bus.seed_out, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        void'(exp_q.pop_back());
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);
        launch(1'b1, 8'h00, SEED_COUNT);
        wait_seed("post_rst", 1'b0);

        ready = 1'b1;
        tick();
        ready = 1'b0;
        launch(1'b1, 8'h00, SEED_COUNT);
        wait_seed("noise", 1'b1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        cnt_mode = 1'b0;

        // STRIDE=1 instance: one capture per clock
        cnt_mode = 1'b1;
        n        = 0;
        rnd_word = 8'h00;
        start2   = 1'b1;
        exp_q.push_back(SEED_S1);
        tick();
        t = 1;
        start2 = 1'b0;
        while (!bus2.seed_valid && t < 100) begin
            tick();
            t++;
        end
        chk("s1_lat", 64'(t), 64'd9);
        check_seed("s1_seed", bus2.seed_out);
        cnt_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
